pim_conv_seq: RTL and testbench

PIM_CONV_SEQ -- requirements
Module: pim_conv_seq

---
 rtl/pim_conv_seq.sv | 140 ++++++++++++++
 tb/tb_pim_conv_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pim_conv_seq.sv
// Bit-serial crossbar convolution sequencer: sweeps columns, feeds one
// input bit-plane per cycle and shift-accumulates the ADC results.
module pim_conv_seq #(
    parameter int INPUT_SIZE = 32,
    parameter int INPUT_P    = 4,
    parameter int NUM_COL    = 32,
    parameter int ADC_P      = 4,
    parameter bit SIGNED_IN  = 1'b0,
    localparam int AW    = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int BW    = (INPUT_P > 1) ? $clog2(INPUT_P) : 1,
    localparam int ACC_W = ADC_P + INPUT_P + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INPUT_SIZE*INPUT_P-1:0] in_feature,
    output logic                          xb_en,
    output logic [INPUT_SIZE-1:0]         xb_bits,
    output logic [AW-1:0]                 xb_addr,
    input  logic [ADC_P-1:0]              xb_adc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       out_data,
    output logic [AW-1:0]                 out_col,
    output logic                          out_last,
    output logic                          busy
);

    typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN, OUT} state_e;

    localparam logic [AW-1:0] LAST_COL = AW'(NUM_COL - 1);
    localparam logic [BW-1:0] LAST_B   = BW'(INPUT_P - 1);

    state_e                          state_q, state_d;
    logic [INPUT_SIZE*INPUT_P-1:0]   feat_q, feat_d;
    logic [AW-1:0]                   col_q, col_d;
    logic [BW-1:0]                   b_q, b_d;
    logic [ACC_W-1:0]                acc_q, acc_d;
    logic                            add_en;
    logic [BW-1:0]                   shamt;
    logic [ACC_W-1:0]                term;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            feat_q  <= '0;
            col_q   <= '0;
            b_q     <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            col_q   <= col_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
        end
    end

    // ADC result arrives one cycle late, so it belongs to plane b-1
    assign term = ACC_W'(xb_adc) << shamt;

    always_comb begin
        state_d   = state_q;
        feat_d    = feat_q;
        col_d     = col_q;
        b_d       = b_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        xb_en     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        add_en    = 1'b0;
        shamt     = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    feat_d  = in_feature;
                    col_d   = '0;
                    b_d     = '0;
                    acc_d   = '0;
                    state_d = COMPUTE;
                end
            end
            COMPUTE: begin
                xb_en = 1'b1;
                if (b_q != '0) begin
                    add_en = 1'b1;
                    shamt  = BW'(b_q - 1'b1);
                end
                if (b_q == LAST_B) state_d = DRAIN;
                else               b_d     = BW'(b_q + 1'b1);
            end
            DRAIN: begin
                add_en  = 1'b1;
                shamt   = LAST_B;
                state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (col_q == LAST_COL) begin
                        state_d = IDLE;
                    end else begin
                        col_d   = AW'(col_q + 1'b1);
                        b_d     = '0;
                        acc_d   = '0;
                        state_d = COMPUTE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (add_en) begin
            if (SIGNED_IN && state_q == DRAIN) acc_d = acc_q - term;
            else                               acc_d = acc_q + term;
        end
    end

    always_comb begin
        logic [INPUT_P-1:0] elem;
        xb_bits = '0;
        xb_addr = '0;
        elem    = '0;
        if (xb_en) begin
            xb_addr = col_q;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                elem       = feat_q[i*INPUT_P +: INPUT_P];
                xb_bits[i] = elem[b_q];
            end
        end
    end

    assign out_data = out_valid ? acc_q : '0;
    assign out_col  = out_valid ? col_q : '0;
    assign out_last = out_valid && (col_q == LAST_COL);

endmodule

// File: tb/tb_pim_conv_seq.sv
// Directed bench for pim_conv_seq: unsigned sweep, signed single column,
// saturation, output stall, mid-job reset and ignored mid-job inputs.
module tb_pim_conv_seq;

    localparam int N    = 32;
    localparam int P    = 4;
    localparam int NC   = 32;
    localparam int ADCP = 4;
    localparam int AW   = 5;
    localparam int ACCW = ADCP + P + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              s_in_valid = 1'b0;
    logic              out_ready = 1'b1;
    logic [N*P-1:0]    in_feature = '0;

    logic              in_ready, xb_en, out_valid, out_last, busy;
    logic [N-1:0]      xb_bits;
    logic [AW-1:0]     xb_addr, out_col;
    logic [ADCP-1:0]   xb_adc = '0;
    logic [ACCW-1:0]   out_data;

    logic              s_in_ready, s_xb_en, s_out_valid, s_out_last, s_busy;
    logic [N-1:0]      s_xb_bits;
    logic [0:0]        s_xb_addr, s_out_col;
    logic [ADCP-1:0]   s_xb_adc = '0;
    logic [ACCW-1:0]   s_out_data;

    int                adc_mode = 0;
    logic [ADCP-1:0]   adc_const = 4'd3;
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;

    pim_conv_seq #(
        .INPUT_SIZE(N), .INPUT_P(P), .NUM_COL(NC),
        .ADC_P(ADCP), .SIGNED_IN(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_feature(in_feature),
        .xb_en(xb_en), .xb_bits(xb_bits), .xb_addr(xb_addr),
        .xb_adc(xb_adc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_col(out_col),
        .out_last(out_last), .busy(busy)
    );

    pim_conv_seq #(
        .INPUT_SIZE(N), .INPUT_P(P), .NUM_COL(1),
        .ADC_P(ADCP), .SIGNED_IN(1'b1)
    ) u_sdut (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_feature(in_feature),
        .xb_en(s_xb_en), .xb_bits(s_xb_bits), .xb_addr(s_xb_addr),
        .xb_adc(s_xb_adc),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_data(s_out_data), .out_col(s_out_col),
        .out_last(s_out_last), .busy(s_busy)
    );

    always #5 clk = ~clk;

    // Crossbar stand-in: answers one cycle after each evaluate strobe
    always @(posedge clk) begin
        cyc <= cyc + 1;
        xb_adc   <= '0;
        s_xb_adc <= s_xb_en ? 4'd1 : 4'd0;
        if (xb_en) begin
            if (adc_mode == 0) xb_adc <= adc_const;
            else               xb_adc <= xb_bits[3:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
    endtask

    task automatic start_job(input logic [N*P-1:0] feat);
        in_feature = feat;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("first_xb_en", 64'(xb_en), 64'd1);
        chk("first_addr", 64'(xb_addr), 64'd0);
        chk("busy_compute", 64'(busy), 64'd1);
        chk("in_ready_busy", 64'(in_ready), 64'd0);
    endtask

    task automatic run_cols(input string tag, input logic [ACCW-1:0] exp);
        int last_cyc = 0;
        for (int c = 0; c < NC; c++) begin
            wait_valid(tag);
            chk({tag, "_data"}, 64'(out_data), 64'(exp));
            chk({tag, "_col"}, 64'(out_col), 64'(c));
            chk({tag, "_last"}, 64'(out_last), 64'(c == NC - 1));
            if (c > 0) chk({tag, "_period"}, 64'(cyc - last_cyc), 64'd6);
            last_cyc = cyc;
            if (c == NC - 1) in_valid = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_idle_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int n;
        logic [N*P-1:0] feat_a;
        logic [N*P-1:0] ones;
        feat_a = '0;
        feat_a[7:0] = 8'h21;
        ones = '1;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_xb_en", 64'(xb_en), 64'd0);
        chk("rst_xb_bits", 64'(xb_bits), 64'd0);
        chk("rst_xb_addr", 64'(xb_addr), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_col", 64'(out_col), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        adc_mode  = 0;
        adc_const = 4'd3;
        start_job(feat_a);
        run_cols("adc3", 9'd45);

        adc_const = 4'd15;
        start_job(ones);
        run_cols("adc15", 9'd225);

        s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        n = 0;
        while (s_out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("signed_timeout", 64'(s_out_valid), 64'd1);
        chk("signed_data", 64'(s_out_data), 64'h1FF);
        chk("signed_col", 64'(s_out_col), 64'd0);
        chk("signed_last", 64'(s_out_last), 64'd1);
        @(negedge clk);
        chk("signed_idle", 64'(s_in_ready), 64'd1);
        chk("signed_no_valid", 64'(s_out_valid), 64'd0);

        adc_const = 4'd3;
        out_ready = 1'b0;
        start_job(feat_a);
        wait_valid("stall");
        for (int k = 0; k < 10; k++) begin
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_data", 64'(out_data), 64'd45);
            chk("stall_xb_en", 64'(xb_en), 64'd0);
            chk("stall_xb_bits", 64'(xb_bits), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("resume_xb_en", 64'(xb_en), 64'd1);
        chk("resume_addr", 64'(xb_addr), 64'd1);

        n = 0;
        while (!(xb_en === 1'b1 && xb_addr == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_col5", 64'(xb_addr), 64'd5);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready", 64'(in_ready), 64'd1);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_xb_en", 64'(xb_en), 64'd0);
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) n++;
        end
        chk("abort_no_result", 64'(n), 64'd0);

        adc_mode = 1;
        start_job(feat_a);
        in_feature = ones;
        in_valid   = 1'b1;
        run_cols("feat", 9'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
